prv32_muldiv: RTL and testbench
===============================

PRV32_MULDIV -- requirements
Module: prv32_muldiv

Interface
REQ-001 The block SHALL have no parameters; the width is fixed at 32 bits.
REQ-002 clk  input  1  Single clock; all state updates on the rising edge.
REQ-003 rst  input  1  Asynchronous, active-low reset.
REQ-004 start  input  1  Request pulse; accepted only in IDLE.
REQ-005 op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 a  input  32  rs1 operand, the dividend or multiplicand.
REQ-007 b  input  32  rs2 operand, the divisor or multiplier.
REQ-008 flush  input  1  Pipeline kill; aborts any operation in flight.
REQ-009 busy  output  1  High in every state except IDLE.
REQ-010 done  output  1  One-cycle pulse; result is valid while done is high.
REQ-011 result  output  32  Registered result, consumed by the EX writeback mux in parallel with the ALU result.

Function
REQ-012 The block SHALL implement states IDLE, MUL, DIV, DONE, with a 6-bit iteration counter.
REQ-013 In IDLE, start=1 and flush=0 at an edge SHALL capture op, a and b, and move to MUL (op<4) or DIV (op>=4); an accepted start is the accept edge.
REQ-014 Operand magnitudes SHALL be taken at the accept edge: a is signed for MULH, MULHSU, DIV and REM; b is signed for MULH, DIV and REM; all other operands are unsigned.
REQ-015 MUL state: shift-add, one multiplier bit per edge, 32 edges, into a 64-bit accumulator; the product is negated at the end if the operand signs differ.
REQ-016 DIV state: restoring division, one quotient bit per edge, 32 edges; the sign is applied afterwards, with quotient sign = sign(a) XOR sign(b) and remainder sign = sign(a).
REQ-017 After the 32nd iteration edge the state SHALL be DONE, so done is high during the cycle that starts 32 edges after the accept edge.
REQ-018 Result selection: MUL gives product[31:0]; MULH, MULHSU and MULHU give product[63:32]; DIV/DIVU give the quotient; REM/REMU give the remainder.
REQ-019 Divide by zero (b=0, op>=4) SHALL bypass DIV and go straight to DONE: quotient 0xFFFFFFFF for both DIV and DIVU, remainder = a; done is high 1 edge after the accept edge.
REQ-020 Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF) SHALL bypass the same way: quotient 0x80000000, remainder 0.
REQ-021 DONE SHALL last exactly one cycle and then return to IDLE; a start during DONE is ignored.
REQ-022 start while busy (MUL, DIV, DONE) SHALL be ignored, and the captured operands SHALL NOT change.
REQ-023 flush=1 at any edge SHALL force IDLE and clear the counter, with done low next cycle; result keeps its previous value.
REQ-024 If flush and start are both high in IDLE, flush SHALL win and the request is not accepted.
REQ-025 result SHALL hold its value from done until the next completing operation.
REQ-026 The block SHALL accept a new start in the first IDLE cycle after DONE, giving back-to-back throughput of one operation per 34 cycles.

Reset
REQ-027 rst=0 SHALL asynchronously force IDLE, counter 0, busy 0, done 0, result 0x00000000, and all internal accumulators to 0.
REQ-028 Reset asserted mid-operation SHALL discard the operation; no done pulse follows the release of reset.
REQ-029 After rst deasserts, the first start SHALL be accepted at the first rising edge.

Verification
REQ-030 MUL, a=0xFFFFFFFF (-1), b=7 -> done 32 cycles after accept, result 0xFFFFFFF9; repeated with MULHU -> 0x00000006; repeated with MULH -> 0xFFFFFFFF.
REQ-031 DIV, a=-7 (0xFFFFFFF9), b=2 -> result 0xFFFFFFFD (-3); REM with the same operands -> 0xFFFFFFFF (-1); DIVU, a=100, b=7 -> 14.
REQ-032 DIVU, a=0x1234, b=0 -> done 1 cycle after accept, result 0xFFFFFFFF; REMU with the same operands -> 0x00001234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
REQ-033 start for MUL 3*5, a second start with different operands at iteration 10, then completion -> result 15 with exactly one done pulse.
REQ-034 DIV started, flush at iteration 20 -> busy low next cycle, no done pulse, result unchanged; a new start the next cycle completes correctly.
REQ-035 rst pulsed low mid-MUL, between clock edges -> busy and done drop immediately, result reads 0, and no done pulse follows.

Source files
------------

// File: rtl/prv32_muldiv.sv
// prv32_muldiv: iterative RV32M multiply/divide unit.
//
// Multiplies with a shift-add loop (one multiplier bit per clock). Divides with
// a restoring loop (one quotient bit per clock). Each takes 32 iteration edges
// after the accept edge. Divide-by-zero and signed overflow go straight to DONE.
//
// Ports
//   clk     in   1   clock, rising edge
//   rst     in   1   asynchronous reset, active low
//   start   in   1   request pulse, accepted only in IDLE
//   op      in   3   RV32M funct3 (MUL..REMU)
//   a       in  32   rs1: multiplicand / dividend
//   b       in  32   rs2: multiplier / divisor
//   flush   in   1   kill the operation in flight
//   busy    out  1   high whenever not IDLE
//   done    out  1   one-cycle pulse, result valid while high
//   result  out 32   registered result, held until the next completion
module prv32_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      state_reg, state_next;
  logic [5:0]  cnt_reg;
  logic [2:0]  op_reg;
  logic [31:0] opnd_reg;    // multiplicand (MUL) or divisor (DIV) magnitude
  logic [63:0] acc_reg;     // MUL: {partial hi, multiplier}; DIV: {remainder, quotient}
  logic        neg_q_reg;   // negate product / quotient at the end
  logic        neg_r_reg;   // negate remainder at the end
  logic [31:0] result_reg;

  // Operand decode at the accept edge
  logic        a_signed, b_signed, sa, sb;
  logic [31:0] mag_a, mag_b;
  logic        div_zero, div_ovf, bypass;
  logic [31:0] bypass_res;

  assign a_signed = (op == 3'd1) | (op == 3'd2) | (op == 3'd4) | (op == 3'd6);
  assign b_signed = (op == 3'd1) | (op == 3'd4) | (op == 3'd6);
  assign sa       = a_signed & a[31];
  assign sb       = b_signed & b[31];
  assign mag_a    = sa ? -a : a;
  assign mag_b    = sb ? -b : b;
  assign div_zero = op[2] & (b == 32'd0);
  assign div_ovf  = op[2] & ~op[0] & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);
  assign bypass   = div_zero | div_ovf;
  // op[1] selects REM/REMU among the divide ops
  assign bypass_res = div_zero ? (op[1] ? a : 32'hFFFF_FFFF)
                               : (op[1] ? 32'd0 : 32'h8000_0000);

  // One shift-add step: add multiplicand to the upper half when the current
  // multiplier bit (acc[0]) is set, then shift the whole accumulator right.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  assign mul_sum  = {1'b0, acc_reg[63:32]} + {1'b0, (acc_reg[0] ? opnd_reg : 32'd0)};
  assign mul_next = {mul_sum, acc_reg[31:1]};

  // One restoring step: shift {rem, quo} left, subtract divisor if it fits.
  // The trial remainder is 33 bits wide; after a subtraction it is below the
  // divisor, so 32 bits hold it.
  logic [32:0] div_top;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] div_next;
  assign div_top  = acc_reg[63:31];
  assign div_ge   = div_top >= {1'b0, opnd_reg};
  assign div_sub  = div_top[31:0] - opnd_reg;
  assign div_next = div_ge ? {div_sub, acc_reg[30:0], 1'b1}
                           : {div_top[31:0], acc_reg[30:0], 1'b0};

  // Sign fix-up and result selection, applied on the final iteration edge
  logic [63:0] prod_fin;
  logic [31:0] quo_fin, rem_fin, fin_res;
  assign prod_fin = neg_q_reg ? -mul_next : mul_next;
  assign quo_fin  = neg_q_reg ? -div_next[31:0]  : div_next[31:0];
  assign rem_fin  = neg_r_reg ? -div_next[63:32] : div_next[63:32];
  assign fin_res  = (state_reg == S_MUL) ? ((op_reg == 3'd0) ? prod_fin[31:0] : prod_fin[63:32])
                                         : (op_reg[1] ? rem_fin : quo_fin);

  logic last_iter;
  assign last_iter = (cnt_reg == 6'd31);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic; flush overrides everything, including a start in IDLE
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: if (start) state_next = bypass ? S_DONE : (op[2] ? S_DIV : S_MUL);
        S_MUL:  if (last_iter) state_next = S_DONE;
        S_DIV:  if (last_iter) state_next = S_DONE;
        S_DONE: state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy   = (state_reg != S_IDLE);
    done   = (state_reg == S_DONE);
    result = result_reg;
  end

  // Datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg    <= 6'd0;
      op_reg     <= 3'd0;
      opnd_reg   <= 32'd0;
      acc_reg    <= 64'd0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      result_reg <= 32'd0;
    end else if (flush) begin
      cnt_reg <= 6'd0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            op_reg    <= op;
            neg_q_reg <= sa ^ sb;
            neg_r_reg <= sa;
            cnt_reg   <= 6'd0;
            if (op[2]) begin
              opnd_reg <= mag_b;
              acc_reg  <= {32'd0, mag_a};
            end else begin
              opnd_reg <= mag_a;
              acc_reg  <= {32'd0, mag_b};
            end
            if (bypass) result_reg <= bypass_res;
          end
        end
        S_MUL: begin
          acc_reg <= mul_next;
          cnt_reg <= cnt_reg + 6'd1;
          if (last_iter) result_reg <= fin_res;
        end
        S_DIV: begin
          acc_reg <= div_next;
          cnt_reg <= cnt_reg + 6'd1;
          if (last_iter) result_reg <= fin_res;
        end
        default: cnt_reg <= 6'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_prv32_muldiv.sv
module tb_prv32_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  prv32_muldiv dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Edge counter; latency is measured in edges from the accept edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   total    = 0;
  int   passed   = 0;
  int   done_cnt = 0;
  logic [31:0] last_exp = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
      $display("ok   %s: got %h", name, act);
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got done with result %h expected no done pulse", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("done_edge", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Issue one request; lat = edges from accept edge to the cycle with done high
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] e, input int lat);
    exp_t t;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    t.res = e;
    t.cyc = cyc + lat;
    sb.push_back(t);
    last_exp = e;
    $display("issue op=%0d a=%h b=%h expect %h in %0d edges", o, x, y, e, lat);
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] e, input int lat);
    issue(o, x, y, e, lat);
    wait_done();
  endtask

  int          d0;
  logic [31:0] prev;

  initial begin
    rst = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    #1;
    chk("reset_busy",   {31'd0, busy}, 32'd0);
    chk("reset_done",   {31'd0, done}, 32'd0);
    chk("reset_result", result,        32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Multiply: -1 * 7 in each flavour
    run(3'd0, 32'hFFFF_FFFF, 32'd7,          32'hFFFF_FFF9, 32);
    run(3'd3, 32'hFFFF_FFFF, 32'd7,          32'h0000_0006, 32);
    run(3'd1, 32'hFFFF_FFFF, 32'd7,          32'hFFFF_FFFF, 32);
    run(3'd2, 32'd2,         32'hFFFF_FFFF,  32'h0000_0001, 32);  // 2 * 4294967295
    // Divide
    run(3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 32);
    run(3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32);
    run(3'd5, 32'd100,       32'd7,          32'd14,        32);
    run(3'd7, 32'd100,       32'd7,          32'd2,         32);
    run(3'd4, 32'd7,         32'hFFFF_FFFE,  32'hFFFF_FFFD, 32);
    run(3'd6, 32'd7,         32'hFFFF_FFFE,  32'd1,         32);
    // Bypass cases: done in the cycle right after the accept edge
    run(3'd5, 32'h0000_1234, 32'd0,          32'hFFFF_FFFF, 0);
    run(3'd7, 32'h0000_1234, 32'd0,          32'h0000_1234, 0);
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 0);
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         0);
    run(3'd6, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFB, 0);

    // Start while busy is ignored; exactly one done
    d0 = done_cnt;
    issue(3'd0, 32'd3, 32'd5, 32'd15, 32);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("busy_mid", {31'd0, busy}, 32'd1);
    op = 3'd3; a = 32'd100; b = 32'd100; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    repeat (5) @(posedge clk);
    chk("one_done", 32'(done_cnt - d0), 32'd1);

    // Flush at iteration 20 of a divide
    prev = last_exp;
    issue(3'd4, 32'd1000, 32'd10, 32'd100, 32);
    repeat (20) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    sb.delete();
    last_exp = prev;
    chk("flush_busy",   {31'd0, busy}, 32'd0);
    chk("flush_result", result,        prev);
    run(3'd4, 32'd1000, 32'hFFFF_FFF6, 32'hFFFF_FF9C, 32);

    // Reset mid-multiply, between clock edges
    issue(3'd0, 32'h0000_1234, 32'h10, 32'h0001_2340, 32);
    repeat (10) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    sb.delete();
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_done",   {31'd0, done}, 32'd0);
    chk("rst_result", result,        32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    d0 = done_cnt;
    repeat (40) @(posedge clk);
    chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
    run(3'd0, 32'd3, 32'd5, 32'd15, 32);

    repeat (5) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
